// File: rtl/rdy_ack_serializer.sv
// Word-to-beat serializer with rdy/ack handshakes on both sides: one wide word in, NB_M1+1 narrow beats out.
// Define SER_BACK2BACK_EN to accept the next word on the last-beat transfer, which removes the idle cycle between words.
module rdy_ack_serializer #(
  parameter int DW_M1 = 7,
  parameter int NB_M1 = 3,
  parameter int CW_M1 = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_rdy,
  output logic                             i_ack,
  input  logic [(NB_M1+1)*(DW_M1+1)-1:0]   i_data,
  output logic                             o_rdy,
  input  logic                             o_ack,
  output logic [DW_M1:0]                   o_data,
  output logic                             o_last,
  output logic [CW_M1:0]                   o_beat,
  output logic                             busy
);

  localparam int DW = DW_M1 + 1;
  localparam int IW = (NB_M1 + 1) * DW;
  localparam logic [CW_M1:0] LAST_BEAT = NB_M1[CW_M1:0];

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   shift_q, shift_d;
  logic [CW_M1:0]  cnt_q, cnt_d;
  logic            accept;
  logic            beatXfer;
  logic            lastBeat;

  assign lastBeat = (cnt_q == LAST_BEAT);
  assign accept   = i_rdy & i_ack;
  assign beatXfer = o_rdy & o_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new word can only be accepted in SEND on the last-beat transfer, and only when back-to-back mode drives i_ack there.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          shift_d = i_data;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (beatXfer) begin
          if (lastBeat) begin
            if (accept) begin
              shift_d = i_data;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q >> DW;
            cnt_d   = cnt_q + (CW_M1+1)'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_rdy  = (state_q == SEND);
    busy   = (state_q == SEND);
    o_data = shift_q[DW-1:0];
    o_beat = cnt_q;
    o_last = (state_q == SEND) & lastBeat;
`ifdef SER_BACK2BACK_EN
    i_ack  = (state_q == IDLE) | ((state_q == SEND) & lastBeat & o_ack);
`else
    i_ack  = (state_q == IDLE);
`endif
  end

endmodule

// File: tb/tb_rdy_ack_serializer.sv
// Scoreboard bench for rdy_ack_serializer: accepted words are sliced into expected beats in a queue,
// and a forked monitor compares every presented beat, the handshake outputs and hold stability.
module tb_rdy_ack_serializer;

  localparam int DW_M1 = 7;
  localparam int NB_M1 = 3;
  localparam int CW_M1 = 1;
  localparam int DW    = DW_M1 + 1;
  localparam int IW    = (NB_M1 + 1) * DW;
`ifdef SER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } beat_t;

  logic            clk;
  logic            rst_n;
  logic            i_rdy;
  logic            i_ack;
  logic [IW-1:0]   i_data;
  logic            o_rdy;
  logic            o_ack;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic [CW_M1:0]  o_beat;
  logic            busy;

  beat_t q[$];
  int    checks;
  int    failures;

  rdy_ack_serializer #(
    .DW_M1(DW_M1),
    .NB_M1(NB_M1),
    .CW_M1(CW_M1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rdy (i_rdy),
    .i_ack (i_ack),
    .i_data(i_data),
    .o_rdy (o_rdy),
    .o_ack (o_ack),
    .o_data(o_data),
    .o_last(o_last),
    .o_beat(o_beat),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [IW-1:0] data, input logic ack);
    i_rdy  = rdy;
    i_data = data;
    o_ack  = ack;
  endtask

  // Every negedge: the beats still owed to downstream define o_rdy, the head beat defines the outputs,
  // and the handshakes seen here are the ones that complete on the coming rising edge.
  task automatic monitorLoop();
    logic          holdPrev;
    logic [DW-1:0] prevData;
    logic [CW_M1:0] prevBeat;
    logic          prevLast;
    logic          expRdy;
    logic          expAck;
    logic          headLast;
    holdPrev = 1'b0;
    prevData = '0;
    prevBeat = '0;
    prevLast = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        holdPrev = 1'b0;
      end else begin
        expRdy   = (q.size() != 0);
        headLast = expRdy && (q[0].idx == NB_M1);
        checkOutput("o_rdy", o_rdy, expRdy);
        checkOutput("busy", busy, expRdy);
        if (expRdy && o_rdy) begin
          checkOutput("o_data", o_data, q[0].data);
          checkOutput("o_beat", o_beat, q[0].idx);
          checkOutput("o_last", o_last, headLast);
        end else begin
          checkOutput("o_last_idle", o_last, 1'b0);
        end
        expAck = !expRdy || (B2B && headLast && o_ack);
        checkOutput("i_ack", i_ack, expAck);
        if (holdPrev) begin
          checkOutput("hold_rdy", o_rdy, 1'b1);
          checkOutput("hold_data", o_data, prevData);
          checkOutput("hold_beat", o_beat, prevBeat);
          checkOutput("hold_last", o_last, prevLast);
        end
        holdPrev = o_rdy && !o_ack;
        prevData = o_data;
        prevBeat = o_beat;
        prevLast = o_last;
        if (o_rdy && o_ack && q.size() != 0) void'(q.pop_front());
        if (i_rdy && i_ack) begin
          for (int i = 0; i <= NB_M1; i++) begin
            beat_t b;
            b.data = i_data[i*DW +: DW];
            b.idx  = i;
            q.push_back(b);
          end
        end
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitAccept();
    logic got;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (i_rdy && i_ack) got = 1'b1;
      nextCycle();
    end
    checkOutput("accept_timeout", got, 1'b1);
  endtask

  task automatic sendWord(input logic [IW-1:0] w);
    i_rdy  = 1'b1;
    i_data = w;
    waitAccept();
    i_rdy  = 1'b0;
  endtask

  task automatic drain(input int n);
    applyStimulus(1'b0, '0, 1'b1);
    repeat (n) nextCycle();
  endtask

  // Reset state first, then the directed scenarios, then a randomized soak with the scoreboard alone.
  initial begin
    int c;
    int acc2;
    int last88;
    checks   = 0;
    failures = 0;
    applyStimulus(1'b0, '0, 1'b0);
    rst_n = 1'b1;
    fork
      monitorLoop();
    join_none
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_o_rdy", o_rdy, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_o_data", o_data, '0);
    checkOutput("rst_o_beat", o_beat, '0);
    checkOutput("rst_o_last", o_last, 1'b0);
    checkOutput("rst_i_ack", i_ack, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    o_ack = 1'b1;
    sendWord(32'hDDCCBBAA);
    for (int k = 0; k <= NB_M1; k++) begin
      logic [31:0] w;
      w = 32'hDDCCBBAA;
      @(negedge clk);
      checkOutput("single_rdy", o_rdy, 1'b1);
      checkOutput("single_data", o_data, w[k*8 +: 8]);
      checkOutput("single_last", o_last, (k == NB_M1));
      nextCycle();
    end
    @(negedge clk);
    checkOutput("single_idle", o_rdy, 1'b0);
    drain(2);

    sendWord(32'hDDCCBBAA);
    nextCycle();
    o_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("bp_rdy", o_rdy, 1'b1);
      checkOutput("bp_data", o_data, 8'hBB);
      checkOutput("bp_beat", o_beat, 1);
      nextCycle();
    end
    o_ack = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("bp_resume", o_data, 8'hCC);
    drain(6);

    c = -1;
    acc2 = -1;
    last88 = -1;
    applyStimulus(1'b1, 32'h44332211, 1'b1);
    for (int k = 0; k < 40 && last88 < 0; k++) begin
      @(negedge clk);
      if (c >= 0) c++;
      if (c < 0 && i_ack) c = 0;
      else if (c > 0 && i_rdy && i_ack && acc2 < 0) acc2 = c;
      if (c > 0 && o_rdy && o_last && o_data == 8'h88) last88 = c;
      nextCycle();
      if (c == 0) i_data = 32'h88776655;
      if (acc2 >= 0) i_rdy = 1'b0;
    end
    checkOutput("b2b_second_accept", acc2, B2B ? 4 : 5);
    checkOutput("b2b_last_beat", last88, B2B ? 8 : 9);
    drain(6);

    sendWord(32'h04030201);
    repeat (NB_M1) nextCycle();
    applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("lastbp_last", o_last, 1'b1);
      checkOutput("lastbp_data", o_data, 8'h04);
      checkOutput("lastbp_i_ack", i_ack, 1'b0);
      nextCycle();
    end
    o_ack = 1'b1;
    waitAccept();
    drain(8);

    repeat (20) begin
      @(negedge clk);
      checkOutput("idle_hold", {o_rdy, busy, i_ack}, 3'b001);
      nextCycle();
    end

    sendWord(32'hDDCCBBAA);
    nextCycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_o_rdy", o_rdy, 1'b0);
    checkOutput("midrst_o_data", o_data, '0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_i_ack", i_ack, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    sendWord(32'hDDCCBBAA);
    @(negedge clk);
    checkOutput("midrst_first", o_data, 8'hAA);
    checkOutput("midrst_beat0", o_beat, 0);
    nextCycle();
    drain(6);

    for (int k = 0; k < 3000; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), IW'($urandom), ($urandom_range(0, 3) != 0));
      nextCycle();
    end
    drain(12);
    checkOutput("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
